// File: rtl/jzjpcc_muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV M-extension multiply/divide unit.
package jzjpcc_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2
    } muldiv_state_t;

    function automatic logic is_signed_a(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_high(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/jzjpcc_muldiv_unit_step.sv
// One radix-2 iteration: shift-add for multiply, trial-subtract/restore for divide.
module jzjpcc_muldiv_unit_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode_i,
    input  logic [XLEN:0]   hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN:0]   hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        sum     = hi_i + {1'b0, (lo_i[0] ? opnd_i : '0)};
        shifted = {hi_i[XLEN-1:0], lo_i[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd_i};
        hi_o    = '0;
        lo_o    = '0;
        if (div_mode_i) begin
            // Borrow out of the extended subtract means the divisor did not fit: restore.
            if (!diff[XLEN+1]) begin
                hi_o = diff[XLEN:0];
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end else begin
                hi_o = shifted;
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_o = {1'b0, sum[XLEN:1]};
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/jzjpcc_muldiv_unit.sv
// Iterative multiply/divide unit: FSM, operand/accumulator registers, sign fix-up and result mux.
// Optional early-out for trivial operands is enabled by defining JZJPCC_MULDIV_FASTPATH_EN.
module jzjpcc_muldiv_unit
    import jzjpcc_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_dbg
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state_q;
    muldiv_op_t      op_q;
    logic            setup_q;
    logic            busy_q;
    logic            valid_q;
    logic [CW-1:0]   count_q;
    logic [XLEN:0]   hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;
    logic [XLEN-1:0] a_raw_q;
    logic [XLEN-1:0] result_q;
    logic            sign_a_q;
    logic            sign_b_q;
    logic            b_zero_q;
    logic            ovf_q;
    logic            zero_q;

    muldiv_op_t      op_in;
    logic            b_zero_in;
    logic            ovf_in;
    logic            zero_in;
    logic            fast_in;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   lo_set_d;
    logic [XLEN-1:0]   opnd_set_d;
    logic [XLEN:0]     hi_step_d;
    logic [XLEN-1:0]   lo_step_d;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_d;
    logic              neg_res;

    // Accept-time decode of the special cases from the live operands.
    always_comb begin
        op_in     = muldiv_op_t'(op);
        b_zero_in = (operand_b == '0);
        ovf_in    = is_div(op_in) && is_signed_a(op_in) && (operand_a == INT_MIN) && (operand_b == '1);
`ifdef JZJPCC_MULDIV_FASTPATH_EN
        zero_in   = (operand_a == '0) || b_zero_in;
        fast_in   = zero_in || ovf_in;
`else
        zero_in   = 1'b0;
        fast_in   = 1'b0;
`endif
    end

    // Setup: two's-complement magnitudes; for multiply, lo holds the multiplier.
    always_comb begin
        mag_a      = sign_a_q ? (-lo_q) : lo_q;
        mag_b      = sign_b_q ? (-opnd_q) : opnd_q;
        lo_set_d   = is_div(op_q) ? mag_a : mag_b;
        opnd_set_d = is_div(op_q) ? mag_b : mag_a;
        if (zero_q) begin
            lo_set_d = '0;
        end
    end

    jzjpcc_muldiv_unit_step #(
        .XLEN(XLEN)
    ) u_step (
        .div_mode_i (is_div(op_q)),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .opnd_i     (opnd_q),
        .hi_o       (hi_step_d),
        .lo_o       (lo_step_d)
    );

    // Finalise: sign fix-up, result select, then the special-case overrides win.
    always_comb begin
        neg_res  = sign_a_q ^ sign_b_q;
        prod     = {hi_q[XLEN-1:0], lo_q};
        prod_fix = neg_res ? (-prod) : prod;
        quo_fix  = neg_res ? (-lo_q) : lo_q;
        rem_fix  = sign_a_q ? (-hi_q[XLEN-1:0]) : hi_q[XLEN-1:0];
        if (is_div(op_q)) begin
            if (b_zero_q) begin
                result_d = is_rem(op_q) ? a_raw_q : '1;
            end else if (ovf_q) begin
                result_d = is_rem(op_q) ? '0 : a_raw_q;
            end else begin
                result_d = is_rem(op_q) ? rem_fix : quo_fix;
            end
        end else begin
            result_d = is_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            setup_q  <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            result_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q     <= op_in;
                        lo_q     <= operand_a;
                        opnd_q   <= operand_b;
                        a_raw_q  <= operand_a;
                        sign_a_q <= is_signed_a(op_in) & operand_a[XLEN-1];
                        sign_b_q <= is_signed_b(op_in) & operand_b[XLEN-1];
                        b_zero_q <= b_zero_in;
                        ovf_q    <= ovf_in;
                        zero_q   <= zero_in;
                        setup_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= fast_in ? FINAL : CALC;
                    end
                end
                CALC: begin
                    if (setup_q) begin
                        hi_q    <= '0;
                        lo_q    <= lo_set_d;
                        opnd_q  <= opnd_set_d;
                        count_q <= '1;
                        setup_q <= 1'b0;
                    end else begin
                        hi_q    <= hi_step_d;
                        lo_q    <= lo_step_d;
                        count_q <= count_q - 1'b1;
                        if (count_q == '0) begin
                            state_q <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    // Early-out ops still spend one cycle in setup before finalising.
                    if (setup_q) begin
                        hi_q    <= '0;
                        lo_q    <= lo_set_d;
                        opnd_q  <= opnd_set_d;
                        setup_q <= 1'b0;
                    end else begin
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_jzjpcc_muldiv_unit.sv
// Scoreboard bench for jzjpcc_muldiv_unit (XLEN=32); honours JZJPCC_MULDIV_FASTPATH_EN for latency.
module tb_jzjpcc_muldiv_unit;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];

`ifdef JZJPCC_MULDIV_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    jzjpcc_muldiv_unit #(.XLEN(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic trivial;
        trivial = (a == 32'd0) || (b == 32'd0) ||
                  (((o == 3'b100) || (o == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
        return (FAST && trivial) ? 2 : 34;
    endfunction

    // monitor
    always @(negedge clock) begin
        if (reset_n && result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result 0x%08h at cycle %0d required no result", result, cyc);
            end else begin
                logic [31:0] e;
                int c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("result", result, e);
                check("latency_cycle", cyc, c);
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: got busy=1 required busy=0 within 200 cycles");
        end
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op        = 3'($urandom_range(0, 7));
        exp_q.push_back(e);
        cyc_q.push_back(cyc + lat(o, a, b));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got %0d pending results required 0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        start     = 1'b0;
        op        = 3'b000;
        operand_a = 32'd0;
        operand_b = 32'd0;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // MUL with busy-duration measurement
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("busy_cycles", n, 32'd34);
        wait_idle();

        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_idle();
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000); wait_idle();
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD); wait_idle();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF); wait_idle();
        issue(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD); wait_idle();
        issue(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1); wait_idle();

        // start pulsed while busy must be ignored
        issue(3'b101, 32'd100, 32'd7, 32'd14);
        repeat (4) @(negedge clock);
        op = 3'b000; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle();

        // back-to-back: second start lands in the result_valid cycle
        issue(3'b111, 32'd100, 32'd7, 32'd2);
        issue(3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1);
        wait_idle();

        // divide by zero, signed overflow, zero operands
        issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF); wait_idle();
        issue(3'b111, 32'd5, 32'd0, 32'd5); wait_idle();
        issue(3'b100, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFFF); wait_idle();
        issue(3'b110, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFEC); wait_idle();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_idle();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0); wait_idle();
        issue(3'b000, 32'd0, 32'd12345, 32'd0); wait_idle();
        issue(3'b100, 32'd0, 32'd5, 32'd0); wait_idle();

        // asynchronous reset mid-operation
        issue(3'b100, 32'd1000, 32'd3, 32'd333);
        repeat (9) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        cyc_q.delete();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, result_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        issue(3'b101, 32'd1000, 32'd3, 32'd333);
        wait_idle();

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
